serial2tcp_tx_arbiter: RTL and testbench
========================================

# serial2tcp_tx_arbiter

Shares the single serial2tcp source byte stream (FPGA -> TCP host) between `NUM_REQ` independent byte-stream requesters. Each requester is granted in round-robin order for a bounded burst. With headers enabled, each burst is prefixed by one header byte carrying the requester ID so the host can demultiplexe the TCP byte stream. The block sits between the on-chip producers and the serial2tcp source port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 16: maximum payload bytes per grant, 1..255.
- `HEADER_EN`, 1: 1 = emit a header byte before each burst; 0 = no header.
- `HDR_MAGIC`, 4'hA: upper nibble of the header byte.
- `sys_clk` input 1: single clock; all logic is rising-edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester byte valid.
- `req_ready` output NUM_REQ: per-requester byte accept.
- `req_data` input 8*NUM_REQ: requester i occupies bits [8i+7:8i].
- `serial2tcp_source_valid` output 1: byte valid toward TCP.
- `serial2tcp_source_ready` input 1: TCP side accepts.
- `serial2tcp_source_data` output 8: byte toward TCP.
- `busy` output 1: high in HDR or DATA.
- `grant_id` output 4: currently or most recently granted requester.

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both high.
  - Producers must hold `valid` and `data` stable until the transfer.
  - Producers must not retract `valid` without a transfer.
- State machine has three states: IDLE, HDR, DATA.
- IDLE:
  - Outputs are zero.
  - If any `req_valid` bit is set, the picker selects the first set bit searching from `last_grant+1` upward with wrap-around.
  - The block latches that index into `grant_id` and `last_grant`, clears `cnt`, and goes to HDR (HEADER_EN=1) or DATA (HEADER_EN=0).
  - With no `req_valid` set, the block stays in IDLE.
- HDR:
  - `source_valid`=1 and `source_data`={HDR_MAGIC, grant_id}.
  - All `req_ready`=0.
  - On transfer, go to DATA.
- DATA is a combinational pass-through of the granted requester only:
  - `source_valid`=`req_valid[g]`, `source_data`=`req_data[g]`, `req_ready[g]`=`source_ready`.
  - All other `req_ready` bits are 0.
  - Each transfer increments `cnt`.
- DATA exit conditions (both return to IDLE):
  - A transfer occurs with `cnt`==MAX_BURST-1.
  - `req_valid[g]`=0 while `cnt`>0, i.e. the requester has gone idle.
- `cnt` width is clog2(MAX_BURST+1). `cnt` never exceeds MAX_BURST-1.
- Requesters not granted see `req_ready`=0 and are never starved: each gets a grant within NUM_REQ-1 other bursts.
- Reset mid-burst:
  - State returns to IDLE.
  - The partially sent burst is truncated, with no trailer. The host resynchronises on the next header.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `cnt`=0, `grant_id`=0.
  - `source_valid`=0, `source_data`=0, `req_ready`=0, `busy`=0.
- `source_data` is forced to 0 whenever `source_valid`=0.
- Arbitration latency:
  - `req_valid` rising at edge N: header is valid from N+1.
  - With HEADER_EN=0: first payload byte is valid from N+1.
- Payload latency in DATA is 0 cycles (combinational valid, data and ready paths).
- Per-burst overhead: 1 IDLE cycle, plus 1 HDR cycle when HEADER_EN=1. Back-to-back bursts always pass through IDLE for one cycle.
- Simultaneous events:
  - A request arriving in the cycle a burst ends is considered in the following IDLE cycle.
  - The current grantee is lowest priority in that cycle.
- Backpressure: `source_ready` low holds the state and `cnt`. The header is held stable until accepted.

## Structure
- Package `serial2tcp_pkg`:
  - state enum `arb_state_t` {IDLE, HDR, DATA}.
  - `HDR_MAGIC_DEFAULT`.
  - function `clog2`.
- One sub-module, `serial2tcp_rr_pick`: purely combinational.
  - Inputs: `req` [NUM_REQ], `last` [4].
  - Outputs: `any`, `idx` [4].
- The top level holds the FSM, `cnt`, `last_grant` and the output muxes.

## Test plan
- Single requester, HEADER_EN=1, NUM_REQ=4, requester 2 streams 0x10..0x13 with ready always high -> output bytes 0xA2,0x10,0x11,0x12,0x13, then IDLE and `busy`=0.
- All four requesters continuously valid, MAX_BURST=3 -> headers appear in order 0xA0,0xA1,0xA2,0xA3,0xA0, each followed by exactly 3 payload bytes.
- `source_ready` toggling 1010… during header and payload -> every byte held stable until accepted, no duplication or loss, `cnt` advances only on transfers.
- Requester 1 sends 2 bytes then drops valid while requester 3 is waiting -> burst ends after 2 bytes; next output is 0xA3 after one IDLE cycle.
- HEADER_EN=0, req 0 and req 1 both valid after reset -> requester 0 is granted first, and its first payload byte appears one cycle after valid rises.
- Assert `sys_rst_n` low mid-DATA after 5 bytes -> all outputs 0 asynchronously. After release, the first grant goes to requester 0 with a fresh header.

Source files
------------

// File: rtl/serial2tcp_pkg.sv
// Shared types and helpers for the serial2tcp TX arbiter.
//   arb_state_t       : arbiter FSM state encoding
//   HDR_MAGIC_DEFAULT : default upper nibble of the burst header byte
//   clog2()           : constant-function ceil(log2(value))
package serial2tcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hA;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial2tcp_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ producers, the arbiter and the serial2tcp source port.
//   req_valid/req_ready/req_data : per-requester streams, requester i at req_data[8i+7:8i]
//   serial2tcp_source_*          : merged stream toward the TCP host
// modport slave  : the arbiter side (accepts requests, drives the source port)
// modport master : the environment side (producers and TCP sink)
interface serial2tcp_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 serial2tcp_source_valid;
    logic                 serial2tcp_source_ready;
    logic [7:0]           serial2tcp_source_data;

    modport slave (
        input  req_valid, req_data, serial2tcp_source_ready,
        output req_ready, serial2tcp_source_valid, serial2tcp_source_data
    );

    modport master (
        output req_valid, req_data, serial2tcp_source_ready,
        input  req_ready, serial2tcp_source_valid, serial2tcp_source_data
    );

endinterface

// File: rtl/serial2tcp_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   last : most recently granted index; search starts at last+1 and wraps
//   any  : at least one request is set
//   idx  : first requesting index found
module serial2tcp_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         last,
    output logic               any,
    output logic [3:0]         idx
);

    logic [15:0] req_ext;
    logic [4:0]  cand;

    always_comb begin
        req_ext = 16'(req);
        any     = 1'b0;
        idx     = '0;
        cand    = '0;
        // k = NUM_REQ reaches last itself, so the previous grantee is checked last.
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = 5'(last) + 5'(k);
            if (cand >= 5'(NUM_REQ)) begin
                cand = cand - 5'(NUM_REQ);
            end
            if (!any && req_ext[cand[3:0]]) begin
                any = 1'b1;
                idx = cand[3:0];
            end
        end
    end

endmodule

// File: rtl/serial2tcp_tx_arbiter.sv
// Round-robin arbiter sharing the serial2tcp source byte stream between NUM_REQ requesters.
// Each grant carries at most MAX_BURST payload bytes, optionally preceded by a header byte
// {HDR_MAGIC, grant_id} so the host can demultiplex the stream.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : requester streams in, serial2tcp source stream out
//   busy               : high while in HDR or DATA
//   grant_id           : current or most recent grantee
module serial2tcp_tx_arbiter
    import serial2tcp_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [3:0]  HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    serial2tcp_tx_arbiter_if.slave       bus,
    output logic                         busy,
    output logic [3:0]                   grant_id
);

    localparam int unsigned      CNT_W    = clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q;
    logic [3:0]       last_grant_q;
    logic [3:0]       grant_id_q;
    logic [CNT_W-1:0] cnt_q;

    logic             pick_any;
    logic [3:0]       pick_idx;

    logic [15:0]      valid_ext;
    logic [127:0]     data_ext;
    logic             g_valid;
    logic [7:0]       g_data;
    logic             src_valid;
    logic [7:0]       src_data;
    logic [NUM_REQ-1:0] ready_vec;

    serial2tcp_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req (bus.req_valid),
        .last(last_grant_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Granted requester's stream, widened so a 4-bit grant index can address it directly.
    always_comb begin
        valid_ext = 16'(bus.req_valid);
        data_ext  = 128'(bus.req_data);
        g_valid   = valid_ext[grant_id_q];
        g_data    = data_ext[{grant_id_q, 3'b000} +: 8];
    end

    // Output muxes: IDLE drives zeros, HDR the header, DATA a pass-through of the grantee.
    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        ready_vec = '0;
        case (state_q)
            HDR: begin
                src_valid = 1'b1;
                src_data  = {HDR_MAGIC, grant_id_q};
            end
            DATA: begin
                src_valid = g_valid;
                src_data  = g_valid ? g_data : 8'h00;
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    ready_vec[i] = (4'(i) == grant_id_q) && bus.serial2tcp_source_ready;
                end
            end
            default: ;
        endcase
    end

    assign bus.serial2tcp_source_valid = src_valid;
    assign bus.serial2tcp_source_data  = src_data;
    assign bus.req_ready               = ready_vec;
    assign busy                        = (state_q != IDLE);
    assign grant_id                    = grant_id_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 4'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_id_q   <= pick_idx;
                        last_grant_q <= pick_idx;
                        cnt_q        <= '0;
                        state_q      <= HEADER_EN ? HDR : DATA;
                    end
                end
                HDR: begin
                    if (bus.serial2tcp_source_ready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (g_valid && bus.serial2tcp_source_ready) begin
                        // Leave on the last byte without incrementing, so cnt stays below MAX_BURST.
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (!g_valid && (cnt_q != '0)) begin
                        // Grantee went idle mid-burst: release the stream early.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial2tcp_tx_arbiter.sv
// Directed bench for serial2tcp_tx_arbiter. Three instances share one set of inputs:
// A = defaults (MAX_BURST 16, headers on), B = MAX_BURST 3, C = HEADER_EN 0.
// sel chooses which instance's outputs drive the producer model and the checks.
module tb_serial2tcp_tx_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        src_ready;

    always #5 sys_clk = ~sys_clk;

    serial2tcp_tx_arbiter_if #(.NUM_REQ(4)) if_a ();
    serial2tcp_tx_arbiter_if #(.NUM_REQ(4)) if_b ();
    serial2tcp_tx_arbiter_if #(.NUM_REQ(4)) if_c ();

    assign if_a.req_valid = req_valid;
    assign if_a.req_data  = req_data;
    assign if_a.serial2tcp_source_ready = src_ready;
    assign if_b.req_valid = req_valid;
    assign if_b.req_data  = req_data;
    assign if_b.serial2tcp_source_ready = src_ready;
    assign if_c.req_valid = req_valid;
    assign if_c.req_data  = req_data;
    assign if_c.serial2tcp_source_ready = src_ready;

    logic       busy_a, busy_b, busy_c;
    logic [3:0] gid_a, gid_b, gid_c;

    serial2tcp_tx_arbiter #(
        .NUM_REQ(4), .MAX_BURST(16), .HEADER_EN(1'b1), .HDR_MAGIC(4'hA)
    ) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_a), .busy(busy_a), .grant_id(gid_a)
    );

    serial2tcp_tx_arbiter #(
        .NUM_REQ(4), .MAX_BURST(3), .HEADER_EN(1'b1), .HDR_MAGIC(4'hA)
    ) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_b), .busy(busy_b), .grant_id(gid_b)
    );

    serial2tcp_tx_arbiter #(
        .NUM_REQ(4), .MAX_BURST(16), .HEADER_EN(1'b0), .HDR_MAGIC(4'hA)
    ) u_dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_c), .busy(busy_c), .grant_id(gid_c)
    );

    int         sel;
    logic       obs_valid;
    logic [7:0] obs_data;
    logic [3:0] obs_ready;
    logic       obs_busy;
    logic [3:0] obs_gid;

    always_comb begin
        case (sel)
            1: begin
                obs_valid = if_b.serial2tcp_source_valid; obs_data = if_b.serial2tcp_source_data;
                obs_ready = if_b.req_ready; obs_busy = busy_b; obs_gid = gid_b;
            end
            2: begin
                obs_valid = if_c.serial2tcp_source_valid; obs_data = if_c.serial2tcp_source_data;
                obs_ready = if_c.req_ready; obs_busy = busy_c; obs_gid = gid_c;
            end
            default: begin
                obs_valid = if_a.serial2tcp_source_valid; obs_data = if_a.serial2tcp_source_data;
                obs_ready = if_a.req_ready; obs_busy = busy_a; obs_gid = gid_a;
            end
        endcase
    end

    // Producer model: per-requester byte buffers, valid while bytes remain.
    logic [7:0] rbuf [4][16];
    int         rhead [4];
    int         rlen [4];
    bit         rdy_toggle;

    // Captured source transfers and a per-cycle trace.
    logic [7:0] out_d [64];
    int         out_c [64];
    int         out_n;
    int         cyc;
    logic       tr_v [64];
    logic [7:0] tr_d [64];
    logic       tr_r [64];

    int total;
    int bad;

    task automatic apply_inputs();
        for (int r = 0; r < 4; r++) begin
            if (rhead[r] < rlen[r]) begin
                req_valid[r]      = 1'b1;
                req_data[8*r +: 8] = rbuf[r][rhead[r]];
            end else begin
                req_valid[r]      = 1'b0;
                req_data[8*r +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) rbuf[r][k] = base + 8'(k);
        rhead[r] = 0;
        rlen[r]  = n;
    endtask

    task automatic clear_queues();
        for (int r = 0; r < 4; r++) begin
            rhead[r] = 0;
            rlen[r]  = 0;
        end
    endtask

    task automatic clear_log();
        out_n = 0;
        cyc   = 0;
    endtask

    // One clock: sample at negedge, advance producers on handshakes, drive #1 after posedge.
    task automatic step();
        logic [3:0] adv;
        @(negedge sys_clk);
        if (cyc < 64) begin
            tr_v[cyc] = obs_valid;
            tr_d[cyc] = obs_data;
            tr_r[cyc] = src_ready;
        end
        if (obs_valid && src_ready && out_n < 64) begin
            out_d[out_n] = obs_data;
            out_c[out_n] = cyc;
            out_n++;
        end
        adv = req_valid & obs_ready;
        @(posedge sys_clk);
        #1;
        for (int r = 0; r < 4; r++) if (adv[r]) rhead[r]++;
        apply_inputs();
        src_ready = rdy_toggle ? ~src_ready : 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        clear_queues();
        apply_inputs();
        src_ready  = 1'b1;
        rdy_toggle = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        clear_log();
    endtask

    task automatic test_reset();
        sel        = 0;
        sys_rst_n  = 1'b0;
        src_ready  = 1'b1;
        rdy_toggle = 1'b0;
        clear_queues();
        load(0, 8'h01, 1);
        apply_inputs();
        #12;
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", obs_valid); end
        total++; if (obs_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", obs_data); end
        total++; if (obs_ready !== 4'h0) begin bad++; $display("FAIL rst_ready: got %h want 0", obs_ready); end
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", obs_busy); end
        total++; if (obs_gid !== 4'h0) begin bad++; $display("FAIL rst_gid: got %h want 0", obs_gid); end
        do_reset();
        repeat (3) step();
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", obs_busy); end
        total++; if (out_n !== 0) begin bad++; $display("FAIL idle_out: got %0d want 0", out_n); end
    endtask

    task automatic test_single();
        logic [7:0] exp_s [5] = '{8'hA2, 8'h10, 8'h11, 8'h12, 8'h13};
        sel = 0;
        clear_log();
        load(2, 8'h10, 4);
        apply_inputs();
        repeat (9) step();
        total++; if (out_n !== 5) begin bad++; $display("FAIL single_count: got %0d want 5", out_n); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_d[i] !== exp_s[i]) begin
                bad++; $display("FAIL single_byte%0d: got %h want %h", i, out_d[i], exp_s[i]);
            end
        end
        total++; if (out_c[0] !== 1) begin bad++; $display("FAIL single_hdr_lat: got %0d want 1", out_c[0]); end
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", obs_busy); end
        total++; if (obs_gid !== 4'h2) begin bad++; $display("FAIL single_gid: got %h want 2", obs_gid); end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_s [4] = '{8'hA0, 8'h31, 8'h32, 8'h33};
        sel = 0;
        clear_log();
        src_ready  = 1'b1;
        rdy_toggle = 1'b1;
        load(0, 8'h31, 3);
        apply_inputs();
        repeat (16) step();
        rdy_toggle = 1'b0;
        src_ready  = 1'b1;
        total++; if (out_n !== 4) begin bad++; $display("FAIL toggle_count: got %0d want 4", out_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_d[i] !== exp_s[i]) begin
                bad++; $display("FAIL toggle_byte%0d: got %h want %h", i, out_d[i], exp_s[i]);
            end
        end
        total++; if (out_c[0] !== 2) begin bad++; $display("FAIL toggle_hdr_cyc: got %0d want 2", out_c[0]); end
        for (int c = 0; c < 15; c++) begin
            if (tr_v[c] && !tr_r[c]) begin
                total++;
                if (tr_v[c+1] !== 1'b1 || tr_d[c+1] !== tr_d[c]) begin
                    bad++;
                    $display("FAIL toggle_hold_c%0d: got v=%b d=%h want v=1 d=%h",
                             c + 1, tr_v[c+1], tr_d[c+1], tr_d[c]);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] exp_s [6] = '{8'hA1, 8'h41, 8'h42, 8'hA3, 8'h61, 8'h62};
        sel = 0;
        clear_log();
        load(1, 8'h41, 2);
        load(3, 8'h61, 2);
        apply_inputs();
        repeat (12) step();
        total++; if (out_n !== 6) begin bad++; $display("FAIL drop_count: got %0d want 6", out_n); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_d[i] !== exp_s[i]) begin
                bad++; $display("FAIL drop_byte%0d: got %h want %h", i, out_d[i], exp_s[i]);
            end
        end
        total++; if (out_c[3] !== 6) begin bad++; $display("FAIL drop_next_hdr_cyc: got %0d want 6", out_c[3]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b;
        int         r;
        do_reset();
        sel = 1;
        for (int q = 0; q < 4; q++) load(q, 8'(q * 16), 6);
        apply_inputs();
        repeat (30) step();
        total++; if (out_n < 20) begin bad++; $display("FAIL rr_count: got %0d want >=20", out_n); end
        for (int b = 0; b < 5; b++) begin
            r = b % 4;
            exp_b = 8'hA0 | 8'(r);
            total++;
            if (out_d[4*b] !== exp_b) begin
                bad++; $display("FAIL rr_hdr%0d: got %h want %h", b, out_d[4*b], exp_b);
            end
            for (int j = 0; j < 3; j++) begin
                exp_b = 8'(r * 16 + (b / 4) * 3 + j);
                total++;
                if (out_d[4*b+1+j] !== exp_b) begin
                    bad++; $display("FAIL rr_b%0d_p%0d: got %h want %h", b, j, out_d[4*b+1+j], exp_b);
                end
            end
        end
    endtask

    task automatic test_no_header();
        logic [7:0] exp_s [3] = '{8'h70, 8'h71, 8'h80};
        do_reset();
        sel = 2;
        load(0, 8'h70, 2);
        load(1, 8'h80, 1);
        apply_inputs();
        repeat (8) step();
        total++; if (out_n !== 3) begin bad++; $display("FAIL nohdr_count: got %0d want 3", out_n); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_d[i] !== exp_s[i]) begin
                bad++; $display("FAIL nohdr_byte%0d: got %h want %h", i, out_d[i], exp_s[i]);
            end
        end
        total++; if (out_c[0] !== 1) begin bad++; $display("FAIL nohdr_lat: got %0d want 1", out_c[0]); end
        total++; if (out_c[2] !== 5) begin bad++; $display("FAIL nohdr_second: got %0d want 5", out_c[2]); end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] exp_s [4] = '{8'hA0, 8'h55, 8'hA1, 8'h95};
        do_reset();
        sel = 0;
        load(1, 8'h90, 10);
        apply_inputs();
        repeat (7) step();
        total++; if (out_n !== 6) begin bad++; $display("FAIL mid_count: got %0d want 6", out_n); end
        total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", obs_busy); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", obs_valid); end
        total++; if (obs_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h want 00", obs_data); end
        total++; if (obs_ready !== 4'h0) begin bad++; $display("FAIL mid_rst_ready: got %h want 0", obs_ready); end
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", obs_busy); end
        total++; if (obs_gid !== 4'h0) begin bad++; $display("FAIL mid_rst_gid: got %h want 0", obs_gid); end
        load(0, 8'h55, 1);
        apply_inputs();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_log();
        repeat (10) step();
        total++; if (out_n < 4) begin bad++; $display("FAIL post_rst_count: got %0d want >=4", out_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_d[i] !== exp_s[i]) begin
                bad++; $display("FAIL post_rst_byte%0d: got %h want %h", i, out_d[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sel       = 0;
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        src_ready = 1'b1;
        clear_log();
        test_reset();
        test_single();
        test_toggle();
        test_drop();
        test_round_robin();
        test_no_header();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
